sram_port_arbiter: RTL and testbench
====================================

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 16, data word width.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 15, word address width.
REQ-003 SHALL have parameter B_STARVE_LIMIT, default 4, max consecutive port-A grants while B waits.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 a_req / b_req  in  1  one-cycle request pulse, port A (CPU) / port B (host).
REQ-007 a_we / b_we  in  1  write enable, sampled with req.
REQ-008 a_addr / b_addr  in  ADDRESS_WIDTH  word address, sampled with req.
REQ-009 a_wdata / b_wdata  in  WORD_WIDTH  write data, sampled with req.
REQ-010 a_done / b_done  out  1  one-cycle completion pulse.
REQ-011 a_rdata / b_rdata  out  WORD_WIDTH  read data, held until that port's next completion.
REQ-012 mem_initialized / mem_busy  in  1  encoder status.
REQ-013 mem_request  out  1  one-cycle request pulse to encoder.
REQ-014 mem_address / mem_write_enable / mem_data_out  out  ADDRESS_WIDTH / 1 / WORD_WIDTH  encoder command; mem_data_out is the write data.
REQ-015 mem_data_in  in  WORD_WIDTH  encoder read data.

Function
REQ-016 Each port SHALL latch req, we, addr and wdata into a pending slot on the edge where req=1.
REQ-017 A req arriving while that port's slot is pending and not completing that cycle SHALL be ignored.
REQ-018 A req in the same cycle as that port's done SHALL be captured as a new pending request.
REQ-019 FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-020 IDLE->ISSUE when mem_initialized=1, mem_busy=0 and any slot is pending; the winner's command SHALL be registered onto mem_address/mem_write_enable/mem_data_out.
REQ-021 ISSUE SHALL drive mem_request=1 for exactly one cycle, then go to WAIT_BUSY.
REQ-022 WAIT_BUSY->WAIT_DONE on mem_busy=1; otherwise it waits without timeout.
REQ-023 WAIT_DONE->IDLE on mem_busy=0.
REQ-024 On the WAIT_DONE->IDLE transition, the winner's rdata SHALL load mem_data_in when the command was a read and stay unchanged when it was a write.
REQ-025 On the same transition, the winner's done SHALL pulse for one cycle and the winner's slot SHALL clear.
REQ-026 Priority: A wins over B, except when B is pending and starve_cnt==B_STARVE_LIMIT; B then wins.
REQ-027 starve_cnt SHALL increment, saturating, on each A grant while B is pending, and clear on each B grant or when B is not pending.
REQ-028 Latency: a req pulse in cycle N with the FSM idle and memory ready SHALL produce mem_request=1 in cycle N+2.
REQ-029 mem_command outputs SHALL hold stable from ISSUE through WAIT_DONE.
REQ-030 No mem_request SHALL be issued while mem_initialized=0; pending requests SHALL wait.
REQ-031 At most one mem_request SHALL be outstanding.
REQ-032 a_done and b_done SHALL never assert in the same cycle.

Reset
REQ-033 On reset=1: state=IDLE, slots cleared, starve_cnt=0, and all outputs 0, including mem_request, done pulses and rdata.
REQ-034 Reset mid-transaction SHALL abort it with no done pulse; a req in a reset cycle SHALL be dropped.

Structure
REQ-035 WORD_WIDTH, ADDRESS_WIDTH and FSM state encoding constants SHALL live in shared package hack_soc_pkg.
REQ-036 The per-port pending slot SHALL be one sub-module, sram_arb_port_latch, instantiated twice.

Verification
REQ-037 A read 0x0123, encoder busy 3 cycles, returns 0xBEEF -> mem_request in cycle N+2, a_done one pulse, a_rdata=0xBEEF.
REQ-038 a_req and b_req in the same cycle -> A served first, then B; b_done follows a_done, never coincident.
REQ-039 B pending, A re-requested 6 times back-to-back, B_STARVE_LIMIT=4 -> B granted after 4th A grant.
REQ-040 Requests while mem_initialized=0 for 20 cycles -> no mem_request until initialized=1, then both served.
REQ-041 B write 0x5555 to 0x4000, then reset asserted in WAIT_DONE -> no b_done, all outputs 0, FSM IDLE.
REQ-042 a_req repeated while A pending -> second ignored; a_req in a_done cycle -> captured and served.

Source files
------------

// File: rtl/hack_soc_pkg.sv
// Shared constants and types for the SRAM port arbiter: default widths,
// FSM state encoding and port identifiers.
package hack_soc_pkg;

    localparam int WORD_WIDTH     = 16;
    localparam int ADDRESS_WIDTH  = 15;
    localparam int B_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } arb_port_e;

    // Counter width able to hold 0..limit.
    function automatic int starve_cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/sram_arb_port_latch.sv
// One-deep pending-request slot for a single arbiter port. A new request is
// accepted when the slot is empty or is being retired in the same cycle.
module sram_arb_port_latch #(
    parameter int WORD_WIDTH    = hack_soc_pkg::WORD_WIDTH,
    parameter int ADDRESS_WIDTH = hack_soc_pkg::ADDRESS_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     req_i,
    input  logic                     we_i,
    input  logic [ADDRESS_WIDTH-1:0] addr_i,
    input  logic [WORD_WIDTH-1:0]    wdata_i,
    input  logic                     clear_i,
    output logic                     pending_o,
    output logic                     we_o,
    output logic [ADDRESS_WIDTH-1:0] addr_o,
    output logic [WORD_WIDTH-1:0]    wdata_o
);

    logic                     pending_q, pending_d;
    logic                     we_q, we_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [WORD_WIDTH-1:0]    wdata_q, wdata_d;

    always_comb begin
        pending_d = pending_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        if (req_i && (!pending_q || clear_i)) begin
            pending_d = 1'b1;
            we_d      = we_i;
            addr_d    = addr_i;
            wdata_d   = wdata_i;
        end else if (clear_i) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pending_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            pending_q <= pending_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign pending_o = pending_q;
    assign we_o      = we_q;
    assign addr_o    = addr_q;
    assign wdata_o   = wdata_q;

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-port (CPU A / host B) arbiter in front of a single SRAM encoder.
// A has priority; B is forced through after B_STARVE_LIMIT consecutive A grants.
module sram_port_arbiter #(
    parameter int WORD_WIDTH     = hack_soc_pkg::WORD_WIDTH,
    parameter int ADDRESS_WIDTH  = hack_soc_pkg::ADDRESS_WIDTH,
    parameter int B_STARVE_LIMIT = hack_soc_pkg::B_STARVE_LIMIT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     a_req,
    input  logic                     a_we,
    input  logic [ADDRESS_WIDTH-1:0] a_addr,
    input  logic [WORD_WIDTH-1:0]    a_wdata,
    output logic                     a_done,
    output logic [WORD_WIDTH-1:0]    a_rdata,
    input  logic                     b_req,
    input  logic                     b_we,
    input  logic [ADDRESS_WIDTH-1:0] b_addr,
    input  logic [WORD_WIDTH-1:0]    b_wdata,
    output logic                     b_done,
    output logic [WORD_WIDTH-1:0]    b_rdata,
    input  logic                     mem_initialized,
    input  logic                     mem_busy,
    output logic                     mem_request,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic                     mem_write_enable,
    output logic [WORD_WIDTH-1:0]    mem_data_out,
    input  logic [WORD_WIDTH-1:0]    mem_data_in
);

    import hack_soc_pkg::*;

    localparam int              CNT_W      = starve_cnt_width(B_STARVE_LIMIT);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(B_STARVE_LIMIT);

    arb_state_e               state_q, state_d;
    arb_port_e                winner_q, winner_d;
    logic [CNT_W-1:0]         starve_q, starve_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic                     we_q, we_d;
    logic [WORD_WIDTH-1:0]    wdata_q, wdata_d;
    logic                     a_done_q, a_done_d;
    logic                     b_done_q, b_done_d;
    logic [WORD_WIDTH-1:0]    a_rdata_q, a_rdata_d;
    logic [WORD_WIDTH-1:0]    b_rdata_q, b_rdata_d;

    logic                     a_pend, a_pwe, b_pend, b_pwe;
    logic [ADDRESS_WIDTH-1:0] a_paddr, b_paddr;
    logic [WORD_WIDTH-1:0]    a_pwdata, b_pwdata;
    logic                     grant_ok, pick_b;

    sram_arb_port_latch #(
        .WORD_WIDTH    (WORD_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_slot_a (
        .clk_i     (clk),
        .reset_i   (reset),
        .req_i     (a_req),
        .we_i      (a_we),
        .addr_i    (a_addr),
        .wdata_i   (a_wdata),
        .clear_i   (a_done_q),
        .pending_o (a_pend),
        .we_o      (a_pwe),
        .addr_o    (a_paddr),
        .wdata_o   (a_pwdata)
    );

    sram_arb_port_latch #(
        .WORD_WIDTH    (WORD_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_slot_b (
        .clk_i     (clk),
        .reset_i   (reset),
        .req_i     (b_req),
        .we_i      (b_we),
        .addr_i    (b_addr),
        .wdata_i   (b_wdata),
        .clear_i   (b_done_q),
        .pending_o (b_pend),
        .we_o      (b_pwe),
        .addr_o    (b_paddr),
        .wdata_o   (b_pwdata)
    );

    // A slot is retired on its done cycle, so no grant is made then; this also
    // lets a same-cycle re-request compete in the following arbitration.
    assign grant_ok = mem_initialized && !mem_busy && (a_pend || b_pend)
                      && !a_done_q && !b_done_q;
    assign pick_b   = b_pend && (!a_pend || (starve_q == STARVE_MAX));

    always_comb begin
        state_d   = state_q;
        winner_d  = winner_q;
        starve_d  = b_pend ? starve_q : '0;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        a_done_d  = 1'b0;
        b_done_d  = 1'b0;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        case (state_q)
            IDLE: begin
                if (grant_ok) begin
                    state_d = ISSUE;
                    if (pick_b) begin
                        winner_d = PORT_B;
                        addr_d   = b_paddr;
                        we_d     = b_pwe;
                        wdata_d  = b_pwdata;
                        starve_d = '0;
                    end else begin
                        winner_d = PORT_A;
                        addr_d   = a_paddr;
                        we_d     = a_pwe;
                        wdata_d  = a_pwdata;
                        if (b_pend && (starve_q != STARVE_MAX)) begin
                            starve_d = starve_q + CNT_W'(1);
                        end
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (mem_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!mem_busy) begin
                    state_d = IDLE;
                    if (winner_q == PORT_A) begin
                        a_done_d = 1'b1;
                        if (!we_q) begin
                            a_rdata_d = mem_data_in;
                        end
                    end else begin
                        b_done_d = 1'b1;
                        if (!we_q) begin
                            b_rdata_d = mem_data_in;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            winner_q  <= PORT_A;
            starve_q  <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            a_done_q  <= 1'b0;
            b_done_q  <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            winner_q  <= winner_d;
            starve_q  <= starve_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            a_done_q  <= a_done_d;
            b_done_q  <= b_done_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    assign mem_request      = (state_q == ISSUE);
    assign mem_address      = addr_q;
    assign mem_write_enable = we_q;
    assign mem_data_out     = wdata_q;
    assign a_done           = a_done_q;
    assign b_done           = b_done_q;
    assign a_rdata          = a_rdata_q;
    assign b_rdata          = b_rdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed and random checks of sram_port_arbiter against a transaction-level
// model of the two request slots, priority/starvation rule and encoder.
module tb_sram_port_arbiter;

    localparam int WW  = 16;
    localparam int AW  = 15;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [WW-1:0] a_wdata, b_wdata;
    logic          a_done, b_done;
    logic [WW-1:0] a_rdata, b_rdata;
    logic          mem_initialized, mem_busy, mem_request, mem_write_enable;
    logic [AW-1:0] mem_address;
    logic [WW-1:0] mem_data_out, mem_data_in;

    always #5 clk = ~clk;

    sram_port_arbiter #(
        .WORD_WIDTH     (WW),
        .ADDRESS_WIDTH  (AW),
        .B_STARVE_LIMIT (LIM)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .a_req            (a_req),
        .a_we             (a_we),
        .a_addr           (a_addr),
        .a_wdata          (a_wdata),
        .a_done           (a_done),
        .a_rdata          (a_rdata),
        .b_req            (b_req),
        .b_we             (b_we),
        .b_addr           (b_addr),
        .b_wdata          (b_wdata),
        .b_done           (b_done),
        .b_rdata          (b_rdata),
        .mem_initialized  (mem_initialized),
        .mem_busy         (mem_busy),
        .mem_request      (mem_request),
        .mem_address      (mem_address),
        .mem_write_enable (mem_write_enable),
        .mem_data_out     (mem_data_out),
        .mem_data_in      (mem_data_in)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        bit            valid;
        bit            we;
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
    } slot_t;

    // Reference model: pending requests per port, one in-flight transaction.
    slot_t         ms [2];
    bit            m_issue, m_active, m_saw_busy, m_started;
    int            m_win, m_starve;
    bit            m_done [2];
    logic [WW-1:0] m_rdata [2];
    logic [AW-1:0] m_addr;
    logic          m_we;
    logic [WW-1:0] m_wd;

    // Encoder behaviour.
    logic [WW-1:0] mem_model [logic [AW-1:0]];
    int            cfg_delay = -1, cfg_len = -1;
    int            enc_wait, enc_len;
    bit            enc_active;
    bit            seen_req, seen_rst, seen_we;
    logic [AW-1:0] seen_addr;
    logic [WW-1:0] seen_wd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("mem_request", 32'(mem_request), 32'(m_issue));
        chk("a_done", 32'(a_done), 32'(m_done[0]));
        chk("b_done", 32'(b_done), 32'(m_done[1]));
        chk("a_rdata", 32'(a_rdata), 32'(m_rdata[0]));
        chk("b_rdata", 32'(b_rdata), 32'(m_rdata[1]));
        chk("mem_address", 32'(mem_address), 32'(m_addr));
        chk("mem_write_enable", 32'(mem_write_enable), 32'(m_we));
        chk("mem_data_out", 32'(mem_data_out), 32'(m_wd));
    endtask

    task automatic model_step();
        slot_t         nxt [2];
        bit            nd [2];
        bit            free, iss;
        logic          rq [2];
        logic          wq [2];
        logic [AW-1:0] ad [2];
        logic [WW-1:0] dt [2];
        rq[0] = a_req; wq[0] = a_we; ad[0] = a_addr; dt[0] = a_wdata;
        rq[1] = b_req; wq[1] = b_we; ad[1] = b_addr; dt[1] = b_wdata;
        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                ms[p] = '{1'b0, 1'b0, '0, '0};
                m_done[p] = 1'b0;
                m_rdata[p] = '0;
            end
            m_issue = 0; m_active = 0; m_saw_busy = 0; m_starve = 0; m_win = 0;
            m_addr = '0; m_we = 1'b0; m_wd = '0;
            m_started = 1;
            return;
        end
        nxt = ms;
        nd[0] = 0; nd[1] = 0;
        iss = 0;
        free = !m_active && !m_done[0] && !m_done[1];
        if (m_active && !m_issue) begin
            if (!m_saw_busy) m_saw_busy = mem_busy;
            else if (!mem_busy) begin
                nd[m_win] = 1;
                if (!m_we) m_rdata[m_win] = mem_data_in;
                m_active = 0;
            end
        end
        if (!ms[1].valid) m_starve = 0;
        if (free && mem_initialized && !mem_busy && (ms[0].valid || ms[1].valid)) begin
            m_win = (ms[1].valid && (!ms[0].valid || m_starve == LIM)) ? 1 : 0;
            if (m_win == 1) m_starve = 0;
            else if (ms[1].valid && m_starve < LIM) m_starve++;
            m_addr = ms[m_win].addr; m_we = ms[m_win].we; m_wd = ms[m_win].data;
            iss = 1; m_active = 1; m_saw_busy = 0;
        end
        for (int p = 0; p < 2; p++) begin
            if (m_done[p]) nxt[p].valid = 0;
            if (rq[p] && (!ms[p].valid || m_done[p])) nxt[p] = '{1'b1, wq[p], ad[p], dt[p]};
        end
        m_issue = iss;
        m_done = nd;
        ms = nxt;
    endtask

    task automatic tick();
        @(negedge clk);
        if (m_started) check_outputs();
        seen_req = mem_request; seen_addr = mem_address;
        seen_we = mem_write_enable; seen_wd = mem_data_out; seen_rst = reset;
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        a_req = 0;
        b_req = 0;
        if (seen_rst) begin
            enc_active = 0;
            mem_busy = 0;
        end else begin
            if (seen_req) begin
                enc_active = 1;
                enc_wait = (cfg_delay >= 0) ? cfg_delay : int'($urandom_range(0, 2));
                enc_len  = (cfg_len > 0) ? cfg_len : int'($urandom_range(1, 4));
                if (seen_we) begin
                    mem_model[seen_addr] = seen_wd;
                    mem_data_in = WW'($urandom);
                end else begin
                    if (!mem_model.exists(seen_addr)) mem_model[seen_addr] = WW'($urandom);
                    mem_data_in = mem_model[seen_addr];
                end
            end
            if (enc_active) begin
                if (enc_wait > 0) begin enc_wait--; mem_busy = 0; end
                else if (enc_len > 0) begin mem_busy = 1; enc_len--; end
                else begin mem_busy = 0; enc_active = 0; end
            end
        end
    endtask

    task automatic wait_done(input int p, input int limit, input string tag);
        bit seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            tick();
            if ((p == 0) ? a_done : b_done) seen = 1;
        end
        chk(tag, 32'(seen), 32'(1));
    endtask

    initial begin
        int n, first, a_cyc, b_cyc, a_dones, a_before, a_issued, cnt;
        bit bdone;
        reset = 1; a_req = 0; b_req = 0; a_we = 0; b_we = 0;
        a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
        mem_initialized = 1; mem_busy = 0; mem_data_in = '0;
        enc_active = 0; m_started = 0;
        repeat (3) tick();
        reset = 0;
        repeat (2) tick();

        // Single read: latency N+2, 3-cycle busy, data 0xBEEF.
        mem_model[15'h0123] = 16'hBEEF;
        cfg_delay = 0; cfg_len = 3;
        n = cyc; first = -1;
        a_req = 1; a_we = 0; a_addr = 15'h0123;
        for (int i = 0; i < 10 && first < 0; i++) begin
            tick();
            if (mem_request) first = cyc;
        end
        chk("req_latency", 32'(first - n), 32'(2));
        wait_done(0, 20, "a_done_read");
        chk("a_rdata_beef", 32'(a_rdata), 32'(16'hBEEF));
        tick();
        chk("a_done_one_pulse", 32'(a_done), 32'(0));
        cfg_delay = -1; cfg_len = -1;

        // Simultaneous requests: A first, then B.
        a_cyc = -1; b_cyc = -1;
        a_req = 1; a_we = 0; a_addr = 15'h0010;
        b_req = 1; b_we = 0; b_addr = 15'h0020;
        for (int i = 0; i < 60 && (a_cyc < 0 || b_cyc < 0); i++) begin
            tick();
            if (a_done && a_cyc < 0) a_cyc = cyc;
            if (b_done && b_cyc < 0) b_cyc = cyc;
        end
        chk("both_done_seen", 32'((a_cyc >= 0) && (b_cyc >= 0)), 32'(1));
        chk("b_after_a", 32'(b_cyc > a_cyc), 32'(1));

        // Starvation: B waits behind back-to-back A requests.
        a_req = 1; a_we = 0; a_addr = 15'h0100;
        b_req = 1; b_we = 1; b_addr = 15'h0200; b_wdata = 16'h1234;
        a_issued = 1; a_dones = 0; a_before = 0; bdone = 0;
        for (int i = 0; i < 400 && !(bdone && a_dones == 6); i++) begin
            tick();
            if (a_done) begin
                a_dones++;
                if (!bdone) a_before++;
                if (a_issued < 6) begin
                    a_req = 1; a_addr = AW'(15'h0100 + a_issued); a_issued++;
                end
            end
            if (b_done) bdone = 1;
        end
        chk("a_grants_before_b", 32'(a_before), 32'(LIM));
        chk("a_total_dones", 32'(a_dones), 32'(6));

        // Encoder not initialized: requests held.
        mem_initialized = 0;
        a_req = 1; a_we = 1; a_addr = 15'h0055; a_wdata = 16'hA0A0;
        b_req = 1; b_we = 0; b_addr = 15'h0066;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mem_request) cnt++;
        end
        chk("no_req_uninit", 32'(cnt), 32'(0));
        mem_initialized = 1;
        wait_done(0, 30, "a_done_after_init");
        wait_done(1, 30, "b_done_after_init");

        // Reset in WAIT_DONE aborts a B write; a_req during reset dropped.
        repeat (3) tick();
        cfg_delay = 0; cfg_len = 6;
        b_req = 1; b_we = 1; b_addr = 15'h4000; b_wdata = 16'h5555;
        for (int i = 0; i < 20 && !mem_busy; i++) tick();
        repeat (2) tick();
        reset = 1; a_req = 1; a_we = 0; a_addr = 15'h0777;
        tick();
        reset = 0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (b_done || a_done || mem_request) cnt++;
        end
        chk("no_activity_after_reset", 32'(cnt), 32'(0));
        chk("rst_a_rdata", 32'(a_rdata), 32'(0));
        chk("rst_b_rdata", 32'(b_rdata), 32'(0));
        chk("rst_mem_address", 32'(mem_address), 32'(0));
        chk("rst_mem_we", 32'(mem_write_enable), 32'(0));
        chk("rst_mem_data_out", 32'(mem_data_out), 32'(0));
        cfg_delay = -1; cfg_len = -1;

        // Second a_req while pending is ignored; one in the done cycle is kept.
        mem_initialized = 0;
        a_req = 1; a_we = 0; a_addr = 15'h0200;
        tick();
        a_req = 1; a_we = 0; a_addr = 15'h0300;
        repeat (2) tick();
        mem_initialized = 1;
        first = -1;
        for (int i = 0; i < 10 && first < 0; i++) begin
            tick();
            if (mem_request) begin first = cyc; chk("first_addr_kept", 32'(mem_address), 32'(15'h0200)); end
        end
        wait_done(0, 20, "a_done_first");
        a_req = 1; a_we = 0; a_addr = 15'h0400;
        first = -1;
        for (int i = 0; i < 10 && first < 0; i++) begin
            tick();
            if (mem_request) begin first = cyc; chk("done_cycle_req_addr", 32'(mem_address), 32'(15'h0400)); end
        end
        wait_done(0, 20, "a_done_second");

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            a_req = ($urandom_range(0, 3) == 0); a_we = 1'($urandom);
            a_addr = AW'($urandom_range(0, 31)); a_wdata = WW'($urandom);
            b_req = ($urandom_range(0, 3) == 0); b_we = 1'($urandom);
            b_addr = AW'($urandom_range(0, 31)); b_wdata = WW'($urandom);
            mem_initialized = ($urandom_range(0, 15) != 0);
            tick();
        end
        mem_initialized = 1;
        repeat (80) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
